// File: rtl/stream_demux2.sv
// stream_demux2: 1-to-2 valid/ready stream demultiplexer.
// Each accepted beat is steered by in_sel into one of two private FIFOs.
// The outputs come straight from FIFO state, so out_ready never reaches in_ready.
module stream_demux2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sel,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out0_valid,
  input  logic                       out0_ready,
  output logic [WIDTH-1:0]           out0_data,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [WIDTH-1:0]           out1_data,
  output logic [$clog2(DEPTH+1)-1:0] out0_count,
  output logic [$clog2(DEPTH+1)-1:0] out1_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]            ready_vec;
  logic [1:0]            valid_vec;
  logic [1:0]            not_full;
  logic [1:0][WIDTH-1:0] data_vec;
  logic [1:0][CW-1:0]    count_vec;

  assign ready_vec = {out1_ready, out0_ready};

  // Acceptance depends only on the selected FIFO's occupancy, never on the consumers.
  assign in_ready = in_sel ? not_full[1] : not_full[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      localparam logic SEL = (gi == 1);

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr;
      logic [PW-1:0]    rd_ptr;
      logic [CW-1:0]    count;
      logic             push;
      logic             pop;

      assign push = in_valid && in_ready && (in_sel == SEL);
      assign pop  = valid_vec[gi] && ready_vec[gi];

      // Storage: cleared on reset so the head reads zero while empty after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (push) begin
          mem[wr_ptr] <= in_data;
        end
      end

      // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
          end
          if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
          end
          case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end

      assign valid_vec[gi] = (count != '0);
      assign not_full[gi]  = (count != CW'(DEPTH));
      assign data_vec[gi]  = mem[rd_ptr];
      assign count_vec[gi] = count;
    end
  endgenerate

  assign out0_valid = valid_vec[0];
  assign out1_valid = valid_vec[1];
  assign out0_data  = data_vec[0];
  assign out1_data  = data_vec[1];
  assign out0_count = count_vec[0];
  assign out1_count = count_vec[1];

endmodule

// File: tb/tb_stream_demux2.sv
// Bench for stream_demux2: a table of per-cycle vectors plus directed
// sequences for reset, pointer wrap and mid-stream reset.
module tb_stream_demux2;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    out0_count;
  logic [CW-1:0]    out1_count;

  int n_vec = 0;
  int n_err = 0;

  stream_demux2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic             is;
    logic [WIDTH-1:0] id;
    logic             r0;
    logic             r1;
    logic             ir;
    logic             v0;
    logic [WIDTH-1:0] d0;
    logic [CW-1:0]    c0;
    logic             v1;
    logic [WIDTH-1:0] d1;
    logic [CW-1:0]    c1;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(logic iv, logic is, logic [WIDTH-1:0] id, logic r0, logic r1,
                              logic ir, logic v0, logic [WIDTH-1:0] d0, int c0,
                              logic v1, logic [WIDTH-1:0] d1, int c1);
    vec_t v;
    v.iv = iv; v.is = is; v.id = id; v.r0 = r0; v.r1 = r1;
    v.ir = ir; v.v0 = v0; v.d0 = d0; v.c0 = CW'(c0);
    v.v1 = v1; v.d1 = d1; v.c1 = CW'(c1);
    return v;
  endfunction

  task automatic drive(logic iv, logic is, logic [WIDTH-1:0] id, logic r0, logic r1);
    in_valid   = iv;
    in_sel     = is;
    in_data    = id;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Data is compared only where the port is valid, unless data_always is set.
  task automatic check(string name, logic ir, logic v0, logic [WIDTH-1:0] d0, int c0,
                       logic v1, logic [WIDTH-1:0] d1, int c1, bit data_always);
    bit bad;
    bad = (in_ready !== ir) || (out0_valid !== v0) || (out1_valid !== v1) ||
          (out0_count !== CW'(c0)) || (out1_count !== CW'(c1)) ||
          ((v0 || data_always) && (out0_data !== d0)) ||
          ((v1 || data_always) && (out1_data !== d1));
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got ir=%0b v0=%0b d0=%h c0=%0d v1=%0b d1=%h c1=%0d, want ir=%0b v0=%0b d0=%h c0=%0d v1=%0b d1=%h c1=%0d",
               name, in_ready, out0_valid, out0_data, out0_count, out1_valid, out1_data, out1_count,
               ir, v0, d0, c0, v1, d1, c1);
    end else begin
      $display("ok   %s: ir=%0b v0=%0b d0=%h c0=%0d v1=%0b d1=%h c1=%0d",
               name, in_ready, out0_valid, out0_data, out0_count, out1_valid, out1_data, out1_count);
    end
  endtask

  initial begin
    //               iv s  data          r0 r1   ir v0 d0            c0 v1 d1            c1
    // single beat to port 1
    vecs[0]  = mk(1, 1, 32'hDEADBEEF, 0, 1,  1, 0, 32'h0,        0, 0, 32'h0,        0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 1,  1, 0, 32'h0,        0, 1, 32'hDEADBEEF, 1);
    vecs[2]  = mk(0, 0, 32'h0,        0, 1,  1, 0, 32'h0,        0, 0, 32'h0,        0);
    // fill port 0 and apply backpressure
    vecs[3]  = mk(1, 0, 32'h11,       0, 0,  1, 0, 32'h0,        0, 0, 32'h0,        0);
    vecs[4]  = mk(1, 0, 32'h22,       0, 0,  1, 1, 32'h11,       1, 0, 32'h0,        0);
    vecs[5]  = mk(1, 0, 32'h33,       0, 0,  0, 1, 32'h11,       2, 0, 32'h0,        0);
    vecs[6]  = mk(1, 0, 32'h33,       1, 0,  0, 1, 32'h11,       2, 0, 32'h0,        0);
    vecs[7]  = mk(1, 0, 32'h33,       0, 0,  1, 1, 32'h22,       1, 0, 32'h0,        0);
    // port 0 full, port 1 streams independently
    vecs[8]  = mk(1, 1, 32'hA0,       0, 1,  1, 1, 32'h22,       2, 0, 32'h0,        0);
    vecs[9]  = mk(1, 1, 32'hA1,       0, 1,  1, 1, 32'h22,       2, 1, 32'hA0,       1);
    vecs[10] = mk(1, 1, 32'hA2,       0, 1,  1, 1, 32'h22,       2, 1, 32'hA1,       1);
    vecs[11] = mk(1, 1, 32'hA3,       0, 1,  1, 1, 32'h22,       2, 1, 32'hA2,       1);
    vecs[12] = mk(0, 1, 32'h0,        0, 1,  1, 1, 32'h22,       2, 1, 32'hA3,       1);
    vecs[13] = mk(0, 0, 32'h0,        0, 1,  0, 1, 32'h22,       2, 0, 32'h0,        0);
    // drain port 0 in order
    vecs[14] = mk(0, 0, 32'h0,        1, 0,  0, 1, 32'h22,       2, 0, 32'h0,        0);
    vecs[15] = mk(0, 0, 32'h0,        1, 0,  1, 1, 32'h33,       1, 0, 32'h0,        0);
    vecs[16] = mk(0, 0, 32'h0,        1, 0,  1, 0, 32'h0,        0, 0, 32'h0,        0);
    // both pops plus a push in one cycle
    vecs[17] = mk(1, 0, 32'hB0,       0, 0,  1, 0, 32'h0,        0, 0, 32'h0,        0);
    vecs[18] = mk(1, 1, 32'hC0,       0, 0,  1, 1, 32'hB0,       1, 0, 32'h0,        0);
    vecs[19] = mk(1, 0, 32'hB1,       1, 1,  1, 1, 32'hB0,       1, 1, 32'hC0,       1);
    vecs[20] = mk(0, 0, 32'h0,        1, 1,  1, 1, 32'hB1,       1, 0, 32'h0,        0);
    vecs[21] = mk(0, 0, 32'h0,        1, 1,  1, 0, 32'h0,        0, 0, 32'h0,        0);

    // Reset is asynchronous: outputs must be at reset values before any clock edge.
    rst_n = 1'b0;
    drive(0, 0, '0, 0, 0);
    #2;
    check("reset", 1, 0, 32'h0, 0, 0, 32'h0, 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].is, vecs[i].id, vecs[i].r0, vecs[i].r1);
      #1;
      check($sformatf("vec%0d", i), vecs[i].ir, vecs[i].v0, vecs[i].d0, vecs[i].c0,
            vecs[i].v1, vecs[i].d1, vecs[i].c1, 1'b0);
    end

    // Wrap: alternate push and pop on port 1 so the pointers wrap many times.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1, 1, WIDTH'(i), 0, 0);
      #1;
      check($sformatf("wrap_push%0d", i), 1, 0, 32'h0, 0, 0, 32'h0, 0, 1'b0);
      @(negedge clk);
      drive(0, 1, '0, 0, 1);
      #1;
      check($sformatf("wrap_pop%0d", i), 1, 0, 32'h0, 0, 1, WIDTH'(i), 1, 1'b0);
    end
    @(negedge clk);
    drive(0, 0, '0, 0, 0);
    #1;
    check("wrap_empty", 1, 0, 32'h0, 0, 0, 32'h0, 0, 1'b0);

    // Mid-stream reset with port 0 full.
    drive(1, 0, 32'h66, 0, 0);
    @(negedge clk);
    drive(1, 0, 32'h77, 0, 0);
    @(negedge clk);
    drive(0, 0, '0, 0, 0);
    #1;
    check("pre_reset_full", 0, 1, 32'h66, 2, 0, 32'h0, 0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset", 1, 0, 32'h0, 0, 0, 32'h0, 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 32'h55, 0, 0);
    #1;
    check("post_reset_push", 1, 0, 32'h0, 0, 0, 32'h0, 0, 1'b0);
    @(negedge clk);
    drive(0, 0, '0, 0, 0);
    #1;
    check("post_reset_out", 1, 1, 32'h55, 1, 0, 32'h0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
